// File: rtl/module_controlador_banco.sv
// Register-file command sequencer: accepts one register-to-register command
// per handshake, reads operands through combinational read ports, runs a
// W-bit ALU and writes the result back to rd. The result and its flags are
// reported to the surrounding datapath with a one-cycle valid pulse.
module module_controlador_banco #(
  parameter  int N  = 32,
  parameter  int W  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [AW-1:0] cmd_rd,
  input  logic [W-1:0]  cmd_imm,
  output logic [AW-1:0] rf_addr_rs1,
  output logic [AW-1:0] rf_addr_rs2,
  output logic [AW-1:0] rf_addr_rd,
  output logic          rf_we,
  output logic [W-1:0]  rf_data_in,
  input  logic [W-1:0]  rf_rs1,
  input  logic [W-1:0]  rf_rs2,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic          res_zero,
  output logic          res_carry
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_RD   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;

  // Latched command fields and captured operands
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [W-1:0]  imm_q;
  logic [W-1:0]  opa_q;
  logic [W-1:0]  opb_q;

  // Result registered at the end of EXEC, published on entry to DONE
  logic [W-1:0]  result_q;
  logic          zero_q;
  logic          carry_q;

  // ALU outputs
  logic [W:0]    alu_wide;
  logic [W-1:0]  alu_res;
  logic          alu_carry;

  // ALU on the captured operands; the W+1-bit wide path yields carry/borrow
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_wide  = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res   = alu_wide[W-1:0];
        alu_carry = alu_wide[W];
      end
      OP_SUB: begin
        // Top bit of the wide difference is the borrow (rs1 < rs2 unsigned)
        alu_wide  = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res   = alu_wide[W-1:0];
        alu_carry = alu_wide[W];
      end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_ADDI: begin
        alu_wide  = {1'b0, opa_q} + {1'b0, imm_q};
        alu_res   = alu_wide[W-1:0];
        alu_carry = alu_wide[W];
      end
      OP_LI:   alu_res = imm_q;
      OP_RD:   alu_res = opa_q;
      default: alu_res = '0;
    endcase
  end

  // Sequencer FSM with registered handshake, register-file and result outputs
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      rf_addr_rs1 <= '0;
      rf_addr_rs2 <= '0;
      rf_addr_rd  <= '0;
      rf_we       <= 1'b0;
      rf_data_in  <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_carry   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q        <= cmd_op;
            rd_q        <= cmd_rd;
            imm_q       <= cmd_imm;
            rf_addr_rs1 <= cmd_rs1;
            rf_addr_rs2 <= cmd_rs2;
            cmd_ready   <= 1'b0;
            state       <= S_READ;
          end else begin
            cmd_ready   <= 1'b1;
          end
        end
        S_READ: begin
          opa_q <= rf_rs1;
          opb_q <= rf_rs2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result_q   <= alu_res;
          zero_q     <= (alu_res == '0);
          carry_q    <= alu_carry;
          // Register 0 is hard-wired zero and RD only reports, so neither writes back
          rf_we      <= (op_q != OP_RD) && (rd_q != '0);
          rf_addr_rd <= rd_q;
          rf_data_in <= alu_res;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          rf_we       <= 1'b0;
          rf_addr_rd  <= '0;
          rf_data_in  <= '0;
          rf_addr_rs1 <= '0;
          rf_addr_rs2 <= '0;
          res_valid   <= 1'b1;
          res_data    <= result_q;
          res_zero    <= zero_q;
          res_carry   <= carry_q;
          state       <= S_DONE;
        end
        S_DONE: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_controlador_banco.sv
// Self-checking bench for module_controlador_banco: a behavioural register
// file closes the loop, a table of directed commands is checked cycle by
// cycle, and hand-written sequences cover reset, back-to-back acceptance
// and reset during write-back.
module tb_module_controlador_banco;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int AW = $clog2(N);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_RD   = 3'b111;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [AW-1:0] cmd_rd;
  logic [W-1:0]  cmd_imm;
  logic [AW-1:0] rf_addr_rs1;
  logic [AW-1:0] rf_addr_rs2;
  logic [AW-1:0] rf_addr_rd;
  logic          rf_we;
  logic [W-1:0]  rf_data_in;
  logic [W-1:0]  rf_rs1;
  logic [W-1:0]  rf_rs2;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_zero;
  logic          res_carry;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [W-1:0]  imm;
    logic [W-1:0]  exp_data;
    logic          exp_zero;
    logic          exp_carry;
    logic          exp_we;
  } vec_t;

  vec_t vecs[14];

  module_controlador_banco #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rd      (cmd_rd),
    .cmd_imm     (cmd_imm),
    .rf_addr_rs1 (rf_addr_rs1),
    .rf_addr_rs2 (rf_addr_rs2),
    .rf_addr_rd  (rf_addr_rd),
    .rf_we       (rf_we),
    .rf_data_in  (rf_data_in),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_carry   (res_carry)
  );

  // Behavioural register file: combinational reads, write on posedge.
  // Register 0 is stored like any other so a stray write to it is visible.
  logic [W-1:0] regs[N];
  assign rf_rs1 = regs[rf_addr_rs1];
  assign rf_rs2 = regs[rf_addr_rs2];

  always @(posedge clk) begin
    if (rf_we) regs[rf_addr_rd] <= rf_data_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [AW-1:0] rs1,
                              input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                              input logic [W-1:0] imm, input logic [W-1:0] d,
                              input logic z, input logic c, input logic we);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
    v.exp_data = d; v.exp_zero = z; v.exp_carry = c; v.exp_we = we;
    return v;
  endfunction

  // Waits (bounded) for cmd_ready; returns 1 when the next posedge is a handshake.
  // Called and returns at a negedge.
  task automatic wait_ready(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Issues one command and checks every cycle from handshake T to T+5.
  task automatic run_cmd(input string name, input vec_t v);
    bit ok;
    cmd_op = v.op; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_rd = v.rd; cmd_imm = v.imm;
    cmd_valid = 1'b1;
    wait_ready(name, ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    // T+1: READ
    check({name, "_read_ready"}, 32'(cmd_ready), 32'd0);
    check({name, "_read_rs1"}, 32'(rf_addr_rs1), 32'(v.rs1));
    check({name, "_read_rs2"}, 32'(rf_addr_rs2), 32'(v.rs2));
    check({name, "_read_we"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    // T+2: EXEC
    check({name, "_exec_we"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    // T+3: WRITE
    check({name, "_wr_we"}, 32'(rf_we), 32'(v.exp_we));
    check({name, "_wr_addr"}, 32'(rf_addr_rd), 32'(v.rd));
    check({name, "_wr_data"}, 32'(rf_data_in), 32'(v.exp_data));
    check({name, "_wr_valid"}, 32'(res_valid), 32'd0);
    @(negedge clk);
    // T+4: DONE
    check({name, "_done_valid"}, 32'(res_valid), 32'd1);
    check({name, "_done_data"}, 32'(res_data), 32'(v.exp_data));
    check({name, "_done_zero"}, 32'(res_zero), 32'(v.exp_zero));
    check({name, "_done_carry"}, 32'(res_carry), 32'(v.exp_carry));
    check({name, "_done_we"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    // T+5: back in IDLE
    check({name, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    check({name, "_idle_valid"}, 32'(res_valid), 32'd0);
    check({name, "_idle_rs1"}, 32'(rf_addr_rs1), 32'd0);
    check({name, "_idle_hold"}, 32'(res_data), 32'(v.exp_data));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, 32'(cmd_ready), 32'd0);
    check({name, "_we"}, 32'(rf_we), 32'd0);
    check({name, "_outs"},
          32'({rf_addr_rs1, rf_addr_rs2, rf_addr_rd, rf_data_in}), 32'd0);
    check({name, "_res"}, 32'({res_valid, res_data, res_zero, res_carry}), 32'd0);
  endtask

  initial begin
    bit ok;
    int accepts;
    int last_acc;

    for (int i = 0; i < N; i++) regs[i] = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_imm = '0;

    //             op       rs1 rs2 rd  imm    data   z     c     we
    vecs[0]  = mk(OP_LI,   0,  0,  1,  8'h7F, 8'h7F, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(OP_LI,   0,  0,  2,  8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    vecs[2]  = mk(OP_ADD,  1,  2,  3,  8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(OP_LI,   0,  0,  4,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    vecs[4]  = mk(OP_ADDI, 4,  0,  5,  8'h01, 8'h00, 1'b1, 1'b1, 1'b1);
    vecs[5]  = mk(OP_SUB,  1,  4,  6,  8'h00, 8'h80, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(OP_AND,  1,  4,  7,  8'h00, 8'h7F, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(OP_OR,   1,  2,  8,  8'h00, 8'h7F, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mk(OP_XOR,  4,  1,  9,  8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(OP_ADD,  4,  2,  0,  8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    vecs[10] = mk(OP_RD,   3,  0,  5,  8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(OP_SUB,  2,  1,  10, 8'h00, 8'h82, 1'b0, 1'b1, 1'b1);
    vecs[12] = mk(OP_SUB,  1,  2,  11, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(OP_RD,   0,  0,  0,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    // Power-on reset: outputs all zero while held, cmd_ready after release
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_ready", 32'(cmd_ready), 32'd1);
    check("por_valid", 32'(res_valid), 32'd0);

    // Directed command table
    for (int i = 0; i < 14; i++) run_cmd($sformatf("v%0d", i), vecs[i]);

    // cmd_valid held high: exactly one acceptance every 5 cycles
    cmd_op = OP_LI; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = 5'd12; cmd_imm = 8'h11;
    cmd_valid = 1'b1;
    accepts = 0;
    last_acc = -1;
    for (int c = 0; c < 20; c++) begin
      if (cmd_ready) begin
        if (last_acc >= 0) check($sformatf("thru_gap%0d", accepts), c - last_acc, 5);
        last_acc = c;
        accepts++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("thru_count", accepts, 4);
    check("thru_r12", 32'(regs[12]), 32'h11);
    wait_ready("thru_drain", ok);

    // Reset while idle: every output drops at once
    rst = 1'b1;
    #1;
    check_all_zero("idle_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rst_ready", 32'(cmd_ready), 32'd1);
    check("idle_rst_valid", 32'(res_valid), 32'd0);

    // Reset during WRITE: LI r1=0x55 must be abandoned, r1 keeps 0x7F
    cmd_op = OP_LI; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = 5'd1; cmd_imm = 8'h55;
    cmd_valid = 1'b1;
    wait_ready("wrst", ok);
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wrst_we_before", 32'(rf_we), 32'd1);
      rst = 1'b1;
      #1;
      check("wrst_we_after", 32'(rf_we), 32'd0);
      check_all_zero("wrst");
      @(negedge clk);
      rst = 1'b0;
      check("wrst_r1", 32'(regs[1]), 32'h7F);
      @(negedge clk);
      check("wrst_ready", 32'(cmd_ready), 32'd1);
    end else begin
      cmd_valid = 1'b0;
    end
    run_cmd("rd_r1", mk(OP_RD, 1, 0, 0, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
